// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state type shared by alu_seq and the control decoder
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: shift-add multiplier / restoring divider on one shared adder (load latches a,b,is_div; run steps one bit; hi/lo partial result; last_iter on final step)
module alu_iter_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last_iter
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] hi_d, hi_q, lo_d, lo_q, d_d, d_q;
  logic [SHW-1:0] cnt_d, cnt_q;
  logic div_d, div_q;
  logic [WIDTH:0] x, y, sum, t;
  always_comb begin
    x = div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    y = {1'b0, d_q};
    sum = div_q ? x - y : x + y;
    t = lo_q[0] ? sum : {1'b0, hi_q};
    hi_d = hi_q;
    lo_d = lo_q;
    d_d = d_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      hi_d = '0;
      lo_d = is_div ? a : b;
      d_d = is_div ? b : a;
      cnt_d = '0;
      div_d = is_div;
    end else if (run) begin
      // divide: keep the trial difference only when it did not borrow
      hi_d = div_q ? (sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0]) : t[WIDTH:1];
      lo_d = div_q ? {lo_q[WIDTH-2:0], ~sum[WIDTH]} : {t[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + SHW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign last_iter = cnt_q == SHW'(WIDTH - 1);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (start/select/A/B in; busy, done pulse, C={HI,LO}, carry, div_by_zero out)
module alu_seq import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         select,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               carry,
  output logic               div_by_zero
);
  localparam int SHW = $clog2(WIDTH);
  state_e state_d, state_q;
  logic [3:0] op_d, op_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q, hi, lo, rol, ror, lo_res;
  logic [2*WIDTH-1:0] c_d, c_q, res;
  logic [WIDTH:0] add, sub;
  logic [SHW-1:0] sh, nsh;
  logic done_d, done_q, carry_d, carry_q, dbz_d, dbz_q;
  logic accept, is_iter, last_iter, b_zero, known;
  always_comb begin
    // DONE only registers the result, so a new op can be accepted in it
    accept = start && state_q != RUN;
    is_iter = select == OP_MUL || (select == OP_DIV && B != '0);
    state_d = accept ? (is_iter ? RUN : DONE) : state_q == RUN ? (last_iter ? DONE : RUN) : IDLE;
    op_d = accept ? select : op_q;
    a_d = accept ? A : a_q;
    b_d = accept ? B : b_q;
    b_zero = b_q == '0;
    sh = b_q[SHW-1:0];
    nsh = -sh;
    rol = (a_q << sh) | (a_q >> nsh);
    ror = (a_q >> sh) | (a_q << nsh);
    add = {1'b0, a_q} + {1'b0, b_q};
    sub = {1'b0, a_q} - {1'b0, b_q};
    lo_res = '0;
    known = 1'b1;
    case (op_q)
      OP_ADD: lo_res = add[WIDTH-1:0];
      OP_SUB: lo_res = sub[WIDTH-1:0];
      OP_AND: lo_res = a_q & b_q;
      OP_OR:  lo_res = a_q | b_q;
      OP_NEG: lo_res = -b_q;
      OP_NOT: lo_res = ~b_q;
      OP_SHL: lo_res = a_q << sh;
      OP_SHR: lo_res = a_q >> sh;
      OP_ROL: lo_res = rol;
      OP_ROR: lo_res = ror;
      default: known = 1'b0;
    endcase
    res = op_q == OP_MUL || (op_q == OP_DIV && !b_zero) ? {hi, lo} :
          op_q == OP_DIV ? {a_q, {WIDTH{1'b1}}} :
          known ? {{WIDTH{1'b0}}, lo_res} : c_q;
    c_d = state_q == DONE ? res : c_q;
    carry_d = state_q == DONE ? (op_q == OP_ADD && add[WIDTH]) || (op_q == OP_SUB && sub[WIDTH]) : carry_q;
    dbz_d = state_q == DONE ? op_q == OP_DIV && b_zero : dbz_q;
    done_d = state_q == DONE;
  end
  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .reset(reset),
    .load(accept && is_iter),
    .is_div(select == OP_DIV),
    .run(state_q == RUN),
    .a(A),
    .b(B),
    .hi(hi),
    .lo(lo),
    .last_iter(last_iter)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      done_q <= 1'b0;
      carry_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      done_q <= done_d;
      carry_q <= carry_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign C = c_q;
  assign carry = carry_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=32
module tb_alu_seq;
  localparam logic [3:0] ADD = 4'h1, SUB = 4'h2, MUL = 4'h3, DIV = 4'h5, AND_ = 4'h6, OR_ = 4'h7;
  localparam logic [3:0] NEG = 4'h8, NOT_ = 4'hA, SHL = 4'hC, SHR = 4'hD, ROL = 4'hE, ROR = 4'hF;
  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] c;
    logic        cy;
    logic        dz;
  } exp_t;
  logic clk, reset, start, busy, done, carry, div_by_zero;
  logic [3:0] select;
  logic [31:0] A, B;
  logic [63:0] C;
  exp_t q[$];
  logic [63:0] model_c;
  int n_chk, n_fail, cyc, t0;
  alu_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .select(select),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .C(C),
    .carry(carry),
    .div_by_zero(div_by_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] pc);
    exp_t e;
    logic [32:0] s;
    logic [31:0] r;
    logic [4:0] sh;
    sh = b[4:0];
    e.op = op;
    e.c = pc;
    e.cy = 1'b0;
    e.dz = 1'b0;
    r = '0;
    case (op)
      ADD: begin s = {1'b0, a} + {1'b0, b}; e.c = {32'b0, s[31:0]}; e.cy = s[32]; end
      SUB: begin r = a - b; e.c = {32'b0, r}; e.cy = a < b; end
      MUL: e.c = {32'b0, a} * {32'b0, b};
      DIV: if (b == 0) begin e.c = {a, 32'hFFFF_FFFF}; e.dz = 1'b1; end
           else e.c = {a % b, a / b};
      AND_: e.c = {32'b0, a & b};
      OR_: e.c = {32'b0, a | b};
      NEG: begin r = 32'd0 - b; e.c = {32'b0, r}; end
      NOT_: e.c = {32'b0, ~b};
      SHL: begin r = a << sh; e.c = {32'b0, r}; end
      SHR: begin r = a >> sh; e.c = {32'b0, r}; end
      ROL: begin r = (a << sh) | (a >> (32 - int'(sh))); e.c = {32'b0, r}; end
      ROR: begin r = (a >> sh) | (a << (32 - int'(sh))); e.c = {32'b0, r}; end
      default: ;
    endcase
    return e;
  endfunction
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      if (q.size() == 0) check("spurious_done", done, 1'b0);
      else begin
        e = q.pop_front();
        check($sformatf("C_op%h", e.op), C, e.c);
        check($sformatf("carry_op%h", e.op), carry, e.cy);
        check($sformatf("dbz_op%h", e.op), div_by_zero, e.dz);
      end
    end
  end
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_start", busy, 1'b0);
    e = model(op, a, b, model_c);
    q.push_back(e);
    model_c = e.c;
    start = 1'b1;
    select = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int n, nb;
    bit seen;
    n = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else nb += int'(busy);
    end
    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("latency", cyc - t0, exp_lat);
      check("busy_cycles", nb, exp_busy);
      check("busy_at_done", busy, 1'b0);
    end
  endtask
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit long_op;
    long_op = op == MUL || (op == DIV && b != 0);
    start_op(op, a, b);
    wait_done(long_op ? 33 : 1, long_op ? 32 : 0);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    t0 = 0;
    model_c = '0;
    reset = 1'b1;
    start = 1'b1;
    select = ADD;
    A = 32'd1;
    B = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_C", C, 64'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_carry", carry, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    check("reset_beats_start", done, 1'b0);
    do_op(ADD, 32'hFFFF_FFFF, 32'd1);
    do_op(SUB, 32'd3, 32'd5);
    do_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(DIV, 32'd100, 32'd7);
    do_op(DIV, 32'd5, 32'd0);
    do_op(ROL, 32'h8000_0001, 32'd36);
    do_op(SHR, 32'h8000_0000, 32'd31);
    do_op(4'b0100, 32'd9, 32'd9);
    do_op(AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
    do_op(OR_, 32'hF000_0001, 32'h0000_1230);
    do_op(NEG, 32'd0, 32'd1);
    do_op(NOT_, 32'd0, 32'h0000_FFFF);
    do_op(SHL, 32'h0000_0003, 32'hFFFF_FFE4);
    do_op(ROR, 32'h0000_0011, 32'd4);
    do_op(ROL, 32'h1234_5678, 32'd0);
    do_op(4'b1011, 32'd1, 32'd2);
    do_op(SUB, 32'd5, 32'd5);
    for (int i = 0; i < 4; i++) begin
      do_op(MUL, $urandom, $urandom);
      do_op(DIV, $urandom, $urandom_range(1, 1000));
    end
    do_op(DIV, 32'd6, 32'd9);
    start_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("busy_mid", busy, 1'b1);
    start = 1'b1;
    select = ADD;
    A = 32'd1;
    B = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    select = DIV;
    wait_done(33, 31);
    do_op(ADD, 32'd10, 32'd20);
    start_op(DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_c = '0;
    @(negedge clk);
    check("abort_C", C, 64'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (40) @(negedge clk);
    do_op(ADD, 32'd7, 32'd8);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the CPU datapath ALU. Single-cycle logic/arithmetic ops complete in one clock, while multiply and divide run on an iterative shift-add / restoring-divide engine taking WIDTH cycles. A start/busy/done handshake lets the control unit stall on long ops. The result is a registered HI:LO pair that feeds the HI/LO and Z registers exactly as the current ALU output does.

## Interface
- WIDTH, 32: operand width; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH): shift/rotate amount width (derived, not overridden).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- select  in  4  opcode, sampled with start.
- A  in  WIDTH  first operand, sampled with start.
- B  in  WIDTH  second operand / shift amount / unary operand, sampled with start.
- busy  out  1  iterative op in progress; start ignored.
- done  out  1  one-cycle pulse; C and flags valid from this cycle.
- C  out  2*WIDTH  {HI, LO} result register.
- carry  out  1  add carry-out / sub borrow-out, else 0.
- div_by_zero  out  1  set with done for DIV with B=0, else 0.

## Operation
- Opcodes: 0001 ADD, 0010 SUB, 0011 MUL, 0101 DIV, 0110 AND, 0111 OR, 1000 NEG (of B), 1010 NOT (of B), 1100 SHL, 1101 SHR (logical), 1110 ROL, 1111 ROR.
- Shift/rotate amount is B[SHW-1:0]; the upper bits of B are ignored.
- Single-cycle ops write their result to LO and clear HI to 0.
- ADD/SUB wrap modulo 2^WIDTH. carry is the carry-out for ADD, or 1 if A<B unsigned for SUB.
- MUL: unsigned A*B, 2*WIDTH result, HI = upper half, LO = lower half.
- DIV: unsigned. LO = quotient, HI = remainder.
- DIV with B=0: LO = all ones, HI = A, div_by_zero = 1, completes as a single-cycle op.
- Undefined opcodes (0000, 0100, 1001, 1011): done pulses, C is unchanged, carry = 0.
- FSM states:
  - IDLE: on start, single-cycle ops go to DONE; MUL, and DIV with B≠0, go to RUN with count = 0.
  - RUN: one iteration per cycle. When count = WIDTH-1, go to DONE.
  - DONE: C, carry and div_by_zero are loaded and done = 1; return to IDLE.
- Operands are latched at start. Changes on A, B or select during RUN have no effect.

## Timing
- start sampled in IDLE at edge t.
- Single-cycle op: done = 1 and C valid in the cycle after edge t+1. busy stays 0.
- MUL/DIV: busy = 1 for cycles t+1 … t+WIDTH. done pulses after edge t+WIDTH+1, with busy = 0 in that cycle. Latency is WIDTH+1 clocks.
- start is accepted in the DONE cycle, so back-to-back ops are allowed. start with busy=1 is dropped, not queued.
- C holds its value until the next done.
- Reset values: C = 0, busy = 0, done = 0, carry = 0, div_by_zero = 0, FSM = IDLE.
- Reset asserted during RUN aborts the op. No done is produced and C reads 0 the next cycle.
- Simultaneous reset and start: reset wins and start is discarded.

## Structure
- Shared package alu_pkg holds the 4-bit opcode localparams (OP_ADD … OP_ROR) and the FSM state enum (IDLE, RUN, DONE). The control unit decoder imports the same package.
- Sub-module alu_iter_core holds the iterative datapath: the shift-add multiplier and the restoring divider. They share one WIDTH+1-bit adder/subtractor, partial-result registers and the iteration counter, and it reports last_iter to the FSM.
- Single-cycle ops are combinational inside alu_seq, registered at DONE.

## Test plan
- Run with WIDTH=32. ADD A=FFFFFFFF, B=1: done at t+1, C=0, carry=1. SUB A=3, B=5: LO=FFFFFFFE, carry=1.
- MUL A=FFFFFFFF, B=FFFFFFFF: busy high for 32 cycles, done at t+33, C=FFFFFFFE_00000001.
- DIV A=100, B=7: HI=2, LO=14, div_by_zero=0. DIV A=5, B=0: done at t+1, HI=5, LO=FFFFFFFF, div_by_zero=1.
- ROL A=80000001, B=24 (amount 4 from the low bits): LO=00000018. SHR A=80000000, B=31: LO=1. HI=0 in both cases.
- start with MUL, then pulse start with ADD during busy and change A/B mid-run: ADD is ignored and the MUL result is unaffected. A new start in the DONE cycle is accepted.
- Assert reset at cycle t+10 of a DIV: no done is produced, C=0 and busy=0 the next cycle, and a following ADD completes normally.
